coldstorage_scheduler: RTL and testbench
========================================

COLDSTORAGE_SCHEDULER -- requirements
Module: coldstorage_scheduler

Interface
REQ-001 Parameters, each SHALL be as listed (name, default, meaning):
 PERIOD_CYC, 100_000_000, clk cycles between sensor polls (1 s at 100 MHz); TIMEOUT_CYC, 30_000_000, max wait for sensor result;
 TEMP_ON, 8'd25, fan-on threshold; TEMP_HYST, 8'd2; HUM_ON, 8'd50, humidifier-on threshold; HUM_HYST, 8'd5; FAULT_LIMIT, 2'd3, consecutive failures to declare fault.
REQ-002 Ports SHALL be (name direction width meaning):
 clk in 1 system clock, 100 MHz; rst_n in 1 reset, synchronous, active-low;
 dht_start out 1 one-cycle request to sensor reader; dht_done in 1 one-cycle result valid; dht_err in 1 one-cycle read failure;
 dht_temp in 8 and dht_hum in 8, valid only with dht_done;
 tx_ready in 1 UART string sender idle; tx_start out 1 one-cycle report request;
 lcd_busy in 1 LCD writer busy; lcd_update out 1 one-cycle refresh request;
 temperature out 8 and humidity out 8 latched last good reading; fan_on out 1; hum_on out 1; sensor_fault out 1; err_count out 8.

Function
REQ-003 Period counter SHALL run freely 0..PERIOD_CYC-1 and raise an internal tick at wrap; a tick in any state other than IDLE SHALL set a single pending flag; additional ticks while pending SHALL be dropped.
REQ-004 FSM states SHALL be IDLE, START, WAIT, LATCH, REPORT.
REQ-005 IDLE -> START on tick or pending flag (flag cleared on the same edge); START SHALL drive dht_start=1 for exactly one cycle, then go to WAIT and clear the timeout counter.
REQ-006 WAIT: dht_err -> failure; else dht_done -> LATCH; else timeout counter reaching TIMEOUT_CYC-1 -> failure. Same-cycle dht_err and dht_done: err wins; dht_done on the timeout cycle: done wins.
REQ-007 Failure SHALL increment err_count (saturating at 255), increment the consecutive-failure counter (saturating), return to IDLE, and leave temperature/humidity/lcd/uart untouched.
REQ-008 LATCH (one cycle) SHALL copy dht_temp/dht_hum to temperature/humidity, clear consecutive failures and sensor_fault, update fan_on/hum_on per REQ-010/011, then enter REPORT.
REQ-009 REPORT SHALL pulse tx_start one cycle at the first cycle tx_ready=1 and pulse lcd_update one cycle at the first cycle lcd_busy=0, independently and each exactly once; both may pulse in the same cycle; exit to IDLE the cycle after both have been issued.
REQ-010 Fan: set when temperature > TEMP_ON; clear when temperature <= TEMP_ON-TEMP_HYST (saturate at 0); otherwise hold.
REQ-011 Humidifier: set when humidity < HUM_ON; clear when humidity >= HUM_ON+HUM_HYST (saturate at 255); otherwise hold.
REQ-012 Consecutive failures reaching FAULT_LIMIT SHALL set sensor_fault=1; while sensor_fault=1, fan_on SHALL be forced 1 and hum_on forced 0 (fail-safe cold, dry).
REQ-013 dht_done/dht_err outside WAIT SHALL be ignored; tx_ready/lcd_busy outside REPORT SHALL be ignored.
REQ-014 All outputs SHALL be registered; dht_start, tx_start, lcd_update SHALL never exceed one cycle high.

Reset
REQ-015 rst_n=0 sampled at a clk edge SHALL, at any state including mid-WAIT or mid-REPORT, return FSM to IDLE and zero period/timeout counters, pending flag, failure counter, err_count, temperature, humidity, fan_on, hum_on, sensor_fault, and all pulse outputs.
REQ-016 First tick after reset release SHALL occur PERIOD_CYC cycles after the first cycle with rst_n=1.

Verification (PERIOD_CYC=100, TIMEOUT_CYC=20)
REQ-017 Normal poll: done with temp=30,hum=40, tx_ready=1, lcd_busy=0 -> temperature=30, humidity=40, fan_on=1, hum_on=1, tx_start and lcd_update pulse once each.
REQ-018 Hysteresis: successive reads temp 30,24,23 and hum 40,52,55 -> fan 1,1,0; hum_on 1,1,0.
REQ-019 Timeout x3: no response -> err_count=1,2,3, sensor_fault=1 after third, fan_on=1, hum_on=0; next good read clears sensor_fault.
REQ-020 Arbitration: dht_err and dht_done same cycle -> treated as failure, temperature unchanged; done on timeout cycle -> accepted.
REQ-021 Handshake stall: tx_ready low 50 cycles, lcd_busy high 10 -> lcd_update at cycle 10, tx_start when tx_ready rises, tick during stall serviced immediately after return to IDLE.
REQ-022 Reset mid-WAIT -> all outputs zero next cycle, no dht_start until PERIOD_CYC cycles after release.

Source files
------------

// File: rtl/coldstorage_scheduler.sv
// -----------------------------------------------------------------------------
// coldstorage_scheduler
//   Polls a temperature/humidity sensor once per PERIOD_CYC clocks, latches the
//   last good reading, drives fan/humidifier with hysteresis, counts read
//   failures and falls back to a cold/dry fail-safe after FAULT_LIMIT
//   consecutive failures. After each good reading it requests one UART report
//   and one LCD refresh.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   dht_start               : one-cycle read request to the sensor reader
//   dht_done / dht_err      : one-cycle read result / read failure
//   dht_temp / dht_hum      : reading, valid only with dht_done
//   tx_ready / tx_start     : UART sender idle / one-cycle report request
//   lcd_busy / lcd_update   : LCD writer busy / one-cycle refresh request
//   temperature / humidity  : last good reading
//   fan_on / hum_on         : actuator controls
//   sensor_fault            : consecutive-failure limit reached
//   err_count               : total failures, saturating at 255
// -----------------------------------------------------------------------------
module coldstorage_scheduler #(
  parameter int unsigned PERIOD_CYC  = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 30_000_000,
  parameter logic [7:0]  TEMP_ON     = 8'd25,
  parameter logic [7:0]  TEMP_HYST   = 8'd2,
  parameter logic [7:0]  HUM_ON      = 8'd50,
  parameter logic [7:0]  HUM_HYST    = 8'd5,
  parameter logic [1:0]  FAULT_LIMIT = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       dht_start,
  input  logic       dht_done,
  input  logic       dht_err,
  input  logic [7:0] dht_temp,
  input  logic [7:0] dht_hum,
  input  logic       tx_ready,
  output logic       tx_start,
  input  logic       lcd_busy,
  output logic       lcd_update,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic       fan_on,
  output logic       hum_on,
  output logic       sensor_fault,
  output logic [7:0] err_count
);

  localparam int unsigned PW = (PERIOD_CYC  > 1) ? $clog2(PERIOD_CYC)  : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);

  // Off thresholds, saturated at the ends of the 8-bit range.
  localparam logic [7:0] FAN_OFF = (TEMP_ON > TEMP_HYST) ? TEMP_ON - TEMP_HYST : 8'd0;
  localparam logic [8:0] HUM_SUM = {1'b0, HUM_ON} + {1'b0, HUM_HYST};
  localparam logic [7:0] HUM_OFF = HUM_SUM[8] ? 8'hFF : HUM_SUM[7:0];

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_LATCH, S_REPORT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q;
  logic [TW-1:0] to_q, to_d;
  logic          pend_q, pend_d;
  logic [1:0]    fail_q, fail_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    rd_temp_q, rd_temp_d, rd_hum_q, rd_hum_d;
  logic [7:0]    temp_q, temp_d, hum_q, hum_d;
  logic          fan_q, fan_d, humon_q, humon_d, fault_q, fault_d;
  logic          tx_done_q, tx_done_d, lcd_done_q, lcd_done_d;
  logic          dht_start_q, dht_start_d, tx_start_q, tx_start_d;
  logic          lcd_update_q, lcd_update_d;
  logic          tick, fail_evt;

  // Free-running poll timer; it never stops, so the poll cadence is fixed
  // regardless of how long a transaction takes.
  assign tick = (per_q == PERIOD_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values independent of statement order.
    if (!rst_n)    per_q <= '0;
    else if (tick) per_q <= '0;
    else           per_q <= per_q + PW'(1);
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    to_d         = to_q;
    pend_d       = pend_q | (tick && state_q != S_IDLE);
    fail_d       = fail_q;
    err_d        = err_q;
    rd_temp_d    = rd_temp_q;
    rd_hum_d     = rd_hum_q;
    temp_d       = temp_q;
    hum_d        = hum_q;
    fan_d        = fan_q;
    humon_d      = humon_q;
    fault_d      = fault_q;
    tx_done_d    = tx_done_q;
    lcd_done_d   = lcd_done_q;
    dht_start_d  = 1'b0;
    tx_start_d   = 1'b0;
    lcd_update_d = 1'b0;
    fail_evt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick || pend_q) begin
          state_d     = S_START;
          pend_d      = 1'b0;
          dht_start_d = 1'b1;   // registered: high exactly during S_START
        end
      end
      S_START: begin
        state_d = S_WAIT;
        to_d    = '0;
      end
      S_WAIT: begin
        // Error beats done; done beats the timeout on the same cycle.
        if (dht_err) begin
          fail_evt = 1'b1;
        end else if (dht_done) begin
          rd_temp_d = dht_temp;  // data is only valid alongside dht_done
          rd_hum_d  = dht_hum;
          state_d   = S_LATCH;
        end else if (to_q == TO_LAST) begin
          fail_evt = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_LATCH: begin
        temp_d     = rd_temp_q;
        hum_d      = rd_hum_q;
        fail_d     = '0;
        fault_d    = 1'b0;
        tx_done_d  = 1'b0;
        lcd_done_d = 1'b0;
        if (rd_temp_q > TEMP_ON)       fan_d = 1'b1;
        else if (rd_temp_q <= FAN_OFF) fan_d = 1'b0;
        if (rd_hum_q < HUM_ON)         humon_d = 1'b1;
        else if (rd_hum_q >= HUM_OFF)  humon_d = 1'b0;
        state_d = S_REPORT;
      end
      S_REPORT: begin
        if (!tx_done_q && tx_ready) begin
          tx_start_d = 1'b1;
          tx_done_d  = 1'b1;
        end
        if (!lcd_done_q && !lcd_busy) begin
          lcd_update_d = 1'b1;
          lcd_done_d   = 1'b1;
        end
        // Leave only once both requests have actually been issued.
        if (tx_done_q && lcd_done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_evt) begin
      err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      fail_d  = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;
      state_d = S_IDLE;
      if (fail_d >= FAULT_LIMIT) begin
        // Fail-safe: keep the store cold and dry while the sensor is unknown.
        fault_d = 1'b1;
        fan_d   = 1'b1;
        humon_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      to_q         <= '0;
      pend_q       <= 1'b0;
      fail_q       <= '0;
      err_q        <= '0;
      rd_temp_q    <= '0;
      rd_hum_q     <= '0;
      temp_q       <= '0;
      hum_q        <= '0;
      fan_q        <= 1'b0;
      humon_q      <= 1'b0;
      fault_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      lcd_done_q   <= 1'b0;
      dht_start_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      lcd_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      pend_q       <= pend_d;
      fail_q       <= fail_d;
      err_q        <= err_d;
      rd_temp_q    <= rd_temp_d;
      rd_hum_q     <= rd_hum_d;
      temp_q       <= temp_d;
      hum_q        <= hum_d;
      fan_q        <= fan_d;
      humon_q      <= humon_d;
      fault_q      <= fault_d;
      tx_done_q    <= tx_done_d;
      lcd_done_q   <= lcd_done_d;
      dht_start_q  <= dht_start_d;
      tx_start_q   <= tx_start_d;
      lcd_update_q <= lcd_update_d;
    end
  end

  assign dht_start    = dht_start_q;
  assign tx_start     = tx_start_q;
  assign lcd_update   = lcd_update_q;
  assign temperature  = temp_q;
  assign humidity     = hum_q;
  assign fan_on       = fan_q;
  assign hum_on       = humon_q;
  assign sensor_fault = fault_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_coldstorage_scheduler.sv
// -----------------------------------------------------------------------------
// tb_coldstorage_scheduler
//   Acts as sensor reader, UART sender and LCD writer around the scheduler.
//   A transaction-level model predicts the reading/actuator/fault state after
//   every poll and the cycle of every dht_start from the poll period and the
//   pending-tick rule.
// -----------------------------------------------------------------------------
module tb_coldstorage_scheduler;

  localparam int P = 100;
  localparam int T = 20;

  localparam int K_OK      = 0;
  localparam int K_ERR     = 1;
  localparam int K_BOTH    = 2;
  localparam int K_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dht_start, dht_done, dht_err;
  logic [7:0] dht_temp, dht_hum;
  logic       tx_ready, tx_start, lcd_busy, lcd_update;
  logic [7:0] temperature, humidity, err_count;
  logic       fan_on, hum_on, sensor_fault;

  coldstorage_scheduler #(
    .PERIOD_CYC (P),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dht_start   (dht_start),
    .dht_done    (dht_done),
    .dht_err     (dht_err),
    .dht_temp    (dht_temp),
    .dht_hum     (dht_hum),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .lcd_busy    (lcd_busy),
    .lcd_update  (lcd_update),
    .temperature (temperature),
    .humidity    (humidity),
    .fan_on      (fan_on),
    .hum_on      (hum_on),
    .sensor_fault(sensor_fault),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int exp_start, exp_tx = 0, exp_lcd = 0;
  int mon_tx = 0, mon_lcd = 0;
  logic mon_prev_ds = 1'b0, mon_prev_tx = 1'b0, mon_prev_lcd = 1'b0;

  // Reference model state
  int m_temp, m_hum, m_err, m_fails;
  int m_fan, m_humon, m_fault;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse monitor: counts requests and checks they never stay high two cycles.
  always @(negedge clk) begin
    if (dht_start) check("dht_start_width", int'(mon_prev_ds), 0);
    if (tx_start) begin
      mon_tx++;
      check("tx_start_width", int'(mon_prev_tx), 0);
    end
    if (lcd_update) begin
      mon_lcd++;
      check("lcd_update_width", int'(mon_prev_lcd), 0);
    end
    mon_prev_ds  = dht_start;
    mon_prev_tx  = tx_start;
    mon_prev_lcd = lcd_update;
  end

  task automatic model_reset();
    m_temp = 0; m_hum = 0; m_err = 0; m_fails = 0;
    m_fan = 0; m_humon = 0; m_fault = 0;
  endtask

  task automatic model_fail();
    if (m_err < 255) m_err++;
    if (m_fails < 3) m_fails++;
    if (m_fails >= 3) begin
      m_fault = 1; m_fan = 1; m_humon = 0;
    end
  endtask

  task automatic model_good(input int t, input int h);
    m_temp = t; m_hum = h; m_fails = 0; m_fault = 0;
    if (t > 25) m_fan = 1;
    else if (t <= 23) m_fan = 0;
    if (h < 50) m_humon = 1;
    else if (h >= 55) m_humon = 0;
  endtask

  // Polls happen P cycles apart; a tick seen while busy is serviced right after
  // the return to idle. s = cycle dht_start was high, idle = first idle cycle.
  function automatic int next_start(input int s, input int idle);
    int r, t0;
    r  = (s - base) % P;
    t0 = s + ((P - 1 - r) + P) % P;   // first tick cycle at or after s
    return (t0 <= idle) ? idle + 1 : t0 + 1;
  endfunction

  task automatic check_outputs();
    check("temperature",  int'(temperature),  m_temp);
    check("humidity",     int'(humidity),     m_hum);
    check("fan_on",       int'(fan_on),       m_fan);
    check("hum_on",       int'(hum_on),       m_humon);
    check("sensor_fault", int'(sensor_fault), m_fault);
    check("err_count",    int'(err_count),    m_err);
  endtask

  task automatic check_zero();
    check("rst_dht_start",  int'(dht_start), 0);
    check("rst_tx_start",   int'(tx_start), 0);
    check("rst_lcd_update", int'(lcd_update), 0);
    check_outputs();
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int n = 0; n < 3 * P; n++) begin
      if (dht_start) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("dht_start_seen", int'(found), 1);
    if (found) begin
      check("dht_start_cycle",  cyc, exp_start);
      check("tx_start_count",   mon_tx, exp_tx);
      check("lcd_update_count", mon_lcd, exp_lcd);
    end
  endtask

  task automatic poll(input int kind, input int t, input int h,
                      input int dly, input int lt, input int lb);
    int s, d, idle, tx_at, lcd_at, last;
    s = cyc;
    if (kind == K_TIMEOUT) begin
      repeat (T + 1) step();
      idle = s + T + 1;
      model_fail();
      check_outputs();
      // A result arriving after the timeout must be ignored.
      dht_done = 1'b1; dht_temp = 8'hEE; dht_hum = 8'hEE;
      step();
      dht_done = 1'b0; dht_temp = '0; dht_hum = '0;
      check("late_done_temp", int'(temperature), m_temp);
      check("late_done_hum",  int'(humidity),    m_hum);
    end else begin
      repeat (dly) step();
      d = cyc;
      dht_temp = 8'(t);
      dht_hum  = 8'(h);
      dht_done = (kind != K_ERR);
      dht_err  = (kind != K_OK);
      if (kind == K_OK) begin
        tx_ready = 1'b0;
        lcd_busy = 1'b1;
      end
      step();
      dht_done = 1'b0; dht_err = 1'b0; dht_temp = '0; dht_hum = '0;
      if (kind != K_OK) begin
        idle = d + 1;
        model_fail();
        check_outputs();
      end else begin
        tx_at  = -1;
        lcd_at = -1;
        last   = 4 + ((lt > lb) ? lt : lb);
        for (int c = 1; c <= last; c++) begin
          if (c > 1) step();
          if (tx_start && tx_at < 0)   tx_at = c;
          if (lcd_update && lcd_at < 0) lcd_at = c;
          tx_ready = (c >= 2 + lt);
          lcd_busy = (c < 2 + lb);
        end
        tx_ready = 1'b1;
        lcd_busy = 1'b0;
        idle = d + last;
        check("tx_start_latency",   tx_at,  3 + lt);
        check("lcd_update_latency", lcd_at, 3 + lb);
        exp_tx++;
        exp_lcd++;
        model_good(t, h);
        check_outputs();
      end
    end
    exp_start = next_start(s, idle);
  endtask

  task automatic run(input int kind, input int t, input int h,
                     input int dly, input int lt, input int lb);
    bit f;
    wait_start(f);
    if (f) poll(kind, t, h, dly, lt, lb);
  endtask

  initial begin
    bit f;
    int kind, r, lt;
    rst_n = 1'b0;
    dht_done = 1'b0; dht_err = 1'b0; dht_temp = '0; dht_hum = '0;
    tx_ready = 1'b1; lcd_busy = 1'b0;
    model_reset();
    repeat (3) step();
    check_zero();

    rst_n = 1'b1;
    base = cyc;
    exp_start = base + P;

    // Normal poll, hysteresis sequence
    run(K_OK, 30, 40, 5, 0, 0);
    run(K_OK, 24, 52, 3, 2, 1);
    run(K_OK, 23, 55, 7, 0, 4);
    // Three timeouts -> fault, then a good read clears it
    run(K_TIMEOUT, 0, 0, 0, 0, 0);
    run(K_TIMEOUT, 0, 0, 0, 0, 0);
    run(K_TIMEOUT, 0, 0, 0, 0, 0);
    run(K_OK, 20, 60, 4, 1, 1);
    // Arbitration: err+done together fails; done on the timeout cycle wins
    run(K_BOTH, 99, 99, 6, 0, 0);
    run(K_OK, 26, 45, T, 0, 0);
    // Handshake stalls; the long one forces a pending tick
    run(K_OK, 27, 48, 2, 50, 10);
    run(K_OK, 22, 58, 2, 110, 10);
    run(K_ERR, 10, 10, 3, 0, 0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      kind = (r <= 5) ? K_OK : (r == 6) ? K_ERR : (r == 7) ? K_BOTH : (r == 8) ? K_TIMEOUT : K_OK;
      lt = (r == 9) ? $urandom_range(40, 120) : $urandom_range(0, 15);
      run(kind, $urandom_range(15, 35), $urandom_range(40, 65),
          $urandom_range(1, T), lt, $urandom_range(0, 15));
    end

    // Reset in the middle of WAIT
    wait_start(f);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    model_reset();
    check_zero();
    rst_n = 1'b1;
    base = cyc;
    exp_start = base + P;
    run(K_OK, 31, 41, 8, 3, 5);
    run(K_ERR, 0, 0, 2, 0, 0);
    wait_start(f);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
